// File: rtl/alu_rr_arbiter_if.sv
// Request/response bus between the requesters and alu_rr_arbiter.
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_op/req_a/req_b  : packed per-requester opcode and operands,
//                         requester i at [i*OPW +: OPW] / [i*W +: W]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_y/rsp_cout : owner id, result and carry of the response
// master: requester/consumer side. slave: arbiter side.
interface alu_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int OPW  = 3,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_op;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_y;
  logic                rsp_cout;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_cout
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_cout
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// A granted request's opcode/operands are registered onto alu_*, the ALU
// result is captured one cycle later and returned on the response channel
// tagged with the requester id.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus          : alu_rr_arbiter_if.slave (request and response channels)
//   alu_op/a/b   : registered opcode/operands to the ALU
//   alu_y/cout   : ALU result and carry/borrow
//   busy         : high whenever the FSM is not idle
// Optional feature: define ALU_ARB_BACK2BACK_EN to allow a new grant in the
// same cycle a response is accepted (RESP -> EXEC without passing IDLE).
module alu_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int OPW  = 3,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  alu_rr_arbiter_if.slave    bus,
  output logic [OPW-1:0]     alu_op,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  input  logic [W-1:0]       alu_y,
  input  logic               alu_cout,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [OPW-1:0] op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   y_q;
  logic           cout_q;
  logic           rsp_valid_q;
  logic           busy_q;

  logic           arb_en;
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] scan_idx;
  logic [IDW-1:0] nxt_ptr;
  logic           accept;

  // Arbitration is open in IDLE, and additionally in RESP on the response
  // handshake when back-to-back issue is enabled.
  always_comb begin
`ifdef ALU_ARB_BACK2BACK_EN
    arb_en = (state == IDLE) || (state == RESP && bus.rsp_ready);
`else
    arb_en = (state == IDLE);
`endif
  end

  // First valid requester scanning from rr_ptr upward, wrapping at NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!grant_vld && bus.req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (arb_en && grant_vld) bus.req_ready[grant_idx] = 1'b1;
  end

  assign accept  = arb_en && grant_vld;
  assign nxt_ptr = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      y_q         <= '0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Operand capture is shared by both grant points (IDLE and, when
      // enabled, RESP); the state update below only decides where to go.
      if (accept) begin
        op_q   <= bus.req_op[grant_idx*OPW +: OPW];
        a_q    <= bus.req_a[grant_idx*W +: W];
        b_q    <= bus.req_b[grant_idx*W +: W];
        id_q   <= grant_idx;
        rr_ptr <= nxt_ptr;
      end
      case (state)
        IDLE: begin
          if (grant_vld) begin
            state  <= EXEC;
            busy_q <= 1'b1;
          end
        end
        EXEC: begin
          y_q         <= alu_y;
          cout_q      <= alu_cout;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
`ifdef ALU_ARB_BACK2BACK_EN
            if (grant_vld) begin
              state <= EXEC;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
`else
            state  <= IDLE;
            busy_q <= 1'b0;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign alu_op        = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_y     = y_q;
  assign bus.rsp_cout  = cout_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int OPW  = 3;
  localparam int IDW  = 2;
  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_SUB = 3'd1;

  logic           clk = 1'b0;
  logic           reset;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_y;
  logic           alu_cout;
  logic           busy;
  logic [W:0]     alu_full;

  int checks = 0;
  int errors = 0;

  alu_rr_arbiter_if #(.NREQ(NREQ), .W(W), .OPW(OPW), .IDW(IDW)) bus ();

  alu_rr_arbiter #(.NREQ(NREQ), .W(W), .OPW(OPW), .IDW(IDW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_y    (alu_y),
    .alu_cout (alu_cout),
    .busy     (busy)
  );

  // Stub ALU: ADD, SUB (cout = borrow), otherwise XOR.
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  alu_full = {1'b0, alu_a} - {1'b0, alu_b};
      default: alu_full = {1'b0, alu_a ^ alu_b};
    endcase
  end
  assign alu_y    = alu_full[W-1:0];
  assign alu_cout = alu_full[W];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_req();
    bus.rsp_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    bus.req_valid    = 4'b0001;
    bus.req_op[2:0]  = OP_ADD;
    bus.req_a[7:0]   = 8'h10;
    bus.req_b[7:0]   = 8'h20;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_pre_grant: req_ready=%b expected 0001", bus.req_ready);
    end
    step();
    clear_req();
    checks++;
    if (alu_a !== 8'h10 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_exec: alu_a=%h busy=%b expected 10 1", alu_a, busy);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL reset_hold_rsp_valid: got %b expected 0", bus.rsp_valid);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || alu_op !== 3'd0 || alu_a !== 8'h00 ||
          alu_b !== 8'h00 || bus.rsp_id !== 2'd0 || bus.rsp_y !== 8'h00 ||
          bus.rsp_cout !== 1'b0 || bus.req_ready !== 4'b0000 || dut.rr_ptr !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs: rsp_valid=%b busy=%b op=%h a=%h b=%h id=%0d y=%h cout=%b ready=%b rr_ptr=%0d expected all 0",
                 bus.rsp_valid, busy, alu_op, alu_a, alu_b, bus.rsp_id, bus.rsp_y,
                 bus.rsp_cout, bus.req_ready, dut.rr_ptr);
      end
    end
  endtask

  task automatic test_single_op();
    bus.rsp_ready    = 1'b1;
    bus.req_valid    = 4'b0100;
    bus.req_op[8:6]  = OP_ADD;
    bus.req_a[23:16] = 8'hF0;
    bus.req_b[23:16] = 8'h20;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant: req_ready=%b expected 0100", bus.req_ready);
    end
    step();
    clear_req();
    checks++;
    if (bus.req_ready !== 4'b0000 || alu_a !== 8'hF0 || alu_b !== 8'h20 ||
        alu_op !== OP_ADD || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_exec: ready=%b a=%h b=%h op=%0d rsp_valid=%b expected 0000 f0 20 0 0",
               bus.req_ready, alu_a, alu_b, alu_op, bus.rsp_valid);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_y !== 8'h10 ||
        bus.rsp_cout !== 1'b1) begin
      errors++;
      $display("FAIL single_resp: valid=%b id=%0d y=%h cout=%b expected 1 2 10 1",
               bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_cout);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 8'hF0) begin
      errors++;
      $display("FAIL single_done: rsp_valid=%b busy=%b alu_a=%h expected 0 0 f0",
               bus.rsp_valid, busy, alu_a);
    end
  endtask

  // rr_ptr is 3 here (last grant went to 2).
  task automatic test_wrap_skip();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0011;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL wrap_grant0: req_ready=%b expected 0001", bus.req_ready);
    end
    step();
    step();
    step();
    checks++;
    if (dut.rr_ptr !== 2'd1 || bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_grant1: rr_ptr=%0d req_ready=%b expected 1 0010", dut.rr_ptr, bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    step();
    step();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 18; c++) begin
      #1;
      exp = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
      checks++;
      if (bus.req_ready !== exp) begin
        errors++; $display("FAIL rr_cycle%0d: req_ready=%b expected %b", c, bus.req_ready, exp);
      end
      step();
    end
    bus.req_valid = '0;
  endtask

  // rr_ptr is 2 here; requester 1 is the only one valid at first.
  task automatic test_backpressure();
    bus.rsp_ready    = 1'b0;
    bus.req_valid    = 4'b0010;
    bus.req_op[5:3]  = OP_SUB;
    bus.req_a[15:8]  = 8'h05;
    bus.req_b[15:8]  = 8'h07;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_grant: req_ready=%b expected 0010", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_y !== 8'hFE ||
          bus.rsp_cout !== 1'b1 || bus.req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b id=%0d y=%h cout=%b ready=%b busy=%b expected 1 1 fe 1 0000 1",
                 i, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_cout, bus.req_ready, busy);
      end
      step();
    end
    clear_req();
    bus.rsp_ready = 1'b1;
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: rsp_valid=%b busy=%b expected 0 0", bus.rsp_valid, busy);
    end
  endtask

`ifdef ALU_ARB_BACK2BACK_EN
  task automatic test_back_to_back();
    logic [NREQ-1:0] exp_rdy;
    logic            exp_vld;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_rdy = (c % 2 == 0) ? (((c / 2) % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
      exp_vld = (c >= 2) && (c % 2 == 0);
      checks++;
      if (bus.req_ready !== exp_rdy || bus.rsp_valid !== exp_vld) begin
        errors++;
        $display("FAIL b2b_cycle%0d: req_ready=%b rsp_valid=%b expected %b %b",
                 c, bus.req_ready, bus.rsp_valid, exp_rdy, exp_vld);
      end
      step();
    end
    bus.req_valid = '0;
    step();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_wrap_skip();
    test_round_robin();
    test_backpressure();
`ifdef ALU_ARB_BACK2BACK_EN
    test_back_to_back();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a task ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational 8-bit ALU between NREQ requesters using round-robin arbitration.
- Grants one requester, registers its opcode and operands, and drives them to the ALU for one cycle.
- Captures the ALU result and returns it on a valid/ready response channel tagged with the requester id.
- Sits between the register-file/sequencer ports and the ALU datapath.

Parameters:
- NREQ, 4, number of requesters; must be 2..8.
- W, 8, operand and result width.
- OPW, 3, ALU opcode width.
- IDW, 2, requester id width; must equal clog2(NREQ).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept, one-hot or zero.
- req_op  in  NREQ*OPW  opcodes; requester i occupies bits [i*OPW +: OPW].
- req_a  in  NREQ*W  operand A per requester, same packing.
- req_b  in  NREQ*W  operand B per requester, same packing.
- alu_op  out  OPW  registered opcode to the ALU.
- alu_a  out  W  registered operand A to the ALU.
- alu_b  out  W  registered operand B to the ALU.
- alu_y  in  W  ALU result; combinational from alu_op, alu_a, alu_b.
- alu_cout  in  1  ALU carry/borrow flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_y  out  W  captured result.
- rsp_cout  out  1  captured carry.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, checked every edge; overrides everything):
  - state=IDLE, rr_ptr=0.
  - op/a/b/id/y/cout registers = 0, so alu_* = 0 and rsp_* = 0.
  - rsp_valid=0, busy=0.
  - An in-flight op is discarded and no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
  - req_ready[grant]=1 combinationally in that same cycle; handshake completes on that edge.
  - On the edge: latch op/a/b of grant, id<=grant, rr_ptr<=(grant+1) mod NREQ, state<=EXEC.
  - No req_valid: stay in IDLE, req_ready=0, rr_ptr unchanged.
- req_ready is 0 in EXEC and RESP. At most one bit is ever set.
- EXEC (exactly 1 cycle):
  - alu_* hold the latched values.
  - On the edge: rsp_y<=alu_y, rsp_cout<=alu_cout, state<=RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_y and rsp_cout are stable until the handshake.
  - rsp_ready=1: state<=IDLE, with rsp_valid deasserting the next cycle.
  - rsp_ready=0: hold indefinitely (backpressure).
- Operand registers keep their values after the op completes; alu_* change only when a new request is accepted.
- Latency: request accept edge to rsp_valid high = 2 cycles. Best-case throughput = 1 op per 3 cycles.
- Fairness: a continuously asserted request waits at most NREQ-1 other grants.
- A requester may deassert req_valid before grant without effect. Operands are sampled only on the accept edge.
- rr_ptr wraps from NREQ-1 to 0.

Optional Feature:
- Macro: ALU_ARB_BACK2BACK_EN.
- Defined:
  - In RESP with rsp_ready=1 and any req_valid, arbitration runs in the same cycle.
  - req_ready is asserted for the winner and the FSM goes RESP->EXEC directly, skipping IDLE.
  - Throughput = 1 op per 2 cycles; rsp_valid deasserts for exactly the EXEC cycle.
  - Fairness and rr_ptr rules are unchanged.
- Undefined: RESP always returns to IDLE, and req_ready is 0 in RESP.

Test Plan:
- Reset/idle: assert reset for 2 cycles mid-EXEC, with requester 0 op=ADD a=8'h10 b=8'h20 accepted the cycle before.
  -> rsp_valid never rises; after reset all outputs are 0, busy=0, rr_ptr=0.
- Single op: req_valid=4'b0100, op=ADD, a=8'hF0, b=8'h20, stub ALU=adder.
  -> req_ready=4'b0100 for 1 cycle; alu_a=8'hF0 next cycle; 2 cycles after accept rsp_valid=1, rsp_id=2, rsp_y=8'h10, rsp_cout=1.
- Round-robin: all four req_valid held high, rsp_ready=1 constantly.
  -> grant order 0,1,2,3,0,1; each grant 3 cycles apart; never two req_ready bits high.
- Backpressure: complete an op with rsp_ready=0 for 5 cycles.
  -> rsp_valid, rsp_id, rsp_y stable for all 5 cycles; req_ready=0 throughout; busy=1; the op completes on the first rsp_ready=1 edge.
- Wrap and skip: rr_ptr=3 after a grant to 2, req_valid=4'b0011.
  -> grant 0, then rr_ptr=1, and the next grant goes to 1.
- With ALU_ARB_BACK2BACK_EN: requesters 1 and 3 held valid, rsp_ready=1.
  -> grants spaced 2 cycles apart (1,3,1,3); rsp_valid pattern 0,1,0,1 after the first op.
